// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared types and protocol constants for the PS/2 mouse sequencer.
// Packet layout follows the standard 3-byte PS/2 stream format.
package ps2_mouse_pkg;

    typedef enum logic [3:0] {
        ST_TX_RST,
        ST_ACK1,
        ST_BAT,
        ST_ID,
        ST_TX_EN,
        ST_ACK2,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_FAIL
    } mouse_state_t;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic       sync;
        logic [2:0] btn;
    } pkt_hdr_t;

    typedef struct packed {
        pkt_hdr_t   hdr;
        logic [7:0] x;
        logic [7:0] y;
    } mouse_packet_t;

    // Byte the device must answer with while the FSM waits in an init state.
    function automatic logic [7:0] init_rsp(mouse_state_t s);
        case (s)
            ST_BAT:  return RSP_BAT_OK;
            ST_ID:   return RSP_ID;
            default: return RSP_ACK;
        endcase
    endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Transceiver handshake and packet/cursor outputs of the mouse sequencer.
interface ps2_mouse_ctrl_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       wr_ps2;
    logic [7:0] tx_data;
    logic       ready;
    logic       init_fail;
    logic       pkt_valid;
    logic [2:0] pkt_btn;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;

    modport master (
        input  rx_done_tick, rx_data, tx_idle, tx_done_tick,
        output wr_ps2, tx_data, ready, init_fail,
               pkt_valid, pkt_btn, pkt_dx, pkt_dy, cursor_x, cursor_y
    );

    modport slave (
        output rx_done_tick, rx_data, tx_idle, tx_done_tick,
        input  wr_ps2, tx_data, ready, init_fail,
               pkt_valid, pkt_btn, pkt_dx, pkt_dy, cursor_x, cursor_y
    );
endinterface

// File: rtl/ps2_mouse_ctrl_cursor.sv
// Screen-clamped cursor accumulator; starts centred and saturates at the edges.
module ps2_mouse_cursor #(
    parameter int unsigned X_MAX = 639,
    parameter int unsigned Y_MAX = 479
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_i,
    input  logic [8:0] dx_i,
    input  logic [8:0] dy_i,
    input  logic       x_ovf_i,
    input  logic       y_ovf_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o
);
    localparam logic signed [11:0] XM = 12'(X_MAX);
    localparam logic signed [11:0] YM = 12'(Y_MAX);

    logic [9:0] x_q, x_d, y_q, y_d;
    logic signed [11:0] dx_eff, dy_eff, x_sum, y_sum;

    assign dx_eff = x_ovf_i ? 12'sd0 : {{3{dx_i[8]}}, dx_i};
    assign dy_eff = y_ovf_i ? 12'sd0 : {{3{dy_i[8]}}, dy_i};
    assign x_sum  = $signed({2'b00, x_q}) + dx_eff;
    // PS/2 reports +y as upward, screen y grows downward.
    assign y_sum  = $signed({2'b00, y_q}) - dy_eff;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (upd_i) begin
            if (x_sum[11])      x_d = '0;
            else if (x_sum > XM) x_d = XM[9:0];
            else                 x_d = x_sum[9:0];
            if (y_sum[11])      y_d = '0;
            else if (y_sum > YM) y_d = YM[9:0];
            else                 y_d = y_sum[9:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= 10'((X_MAX + 1) / 2);
            y_q <= 10'((Y_MAX + 1) / 2);
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: reset/enable handshake with timeout and retry,
// then 3-byte stream packet assembly feeding the cursor accumulator.
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned X_MAX          = 639,
    parameter int unsigned Y_MAX          = 479
) (
    input logic             clk,
    input logic             rst,
    ps2_mouse_ctrl_if.master bus
);
    localparam int unsigned     TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned     RW       = $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]   LAST_TRY = RW'(MAX_RETRIES - 1);

    mouse_state_t  state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          sent_q, sent_d;
    logic          wr_q, wr_d;
    logic [7:0]    txd_q, txd_d;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d;
    logic          pv_q;
    logic [2:0]    btn_q;
    logic [8:0]    dx_q, dy_q;
    logic          enter, bad, upd, counting, tmo_exp;
    mouse_packet_t pkt_w;

    assign pkt_w    = {b0_q, b1_q, bus.rx_data};
    assign counting = !(state_q inside {ST_S0, ST_FAIL});
    assign tmo_exp  = counting && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        sent_d  = sent_q;
        wr_d    = 1'b0;
        txd_d   = txd_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        enter   = 1'b0;
        bad     = 1'b0;
        upd     = 1'b0;
        case (state_q)
            ST_TX_RST, ST_TX_EN: begin
                if (bus.tx_idle && !sent_q) begin
                    wr_d   = 1'b1;
                    sent_d = 1'b1;
                    txd_d  = (state_q == ST_TX_RST) ? CMD_RESET : CMD_ENABLE;
                end
                // Completion beats a coincident timeout.
                if (bus.tx_done_tick) begin
                    state_d = (state_q == ST_TX_RST) ? ST_ACK1 : ST_ACK2;
                    enter   = 1'b1;
                end else if (tmo_exp) begin
                    bad = 1'b1;
                end
            end
            ST_ACK1, ST_BAT, ST_ID, ST_ACK2: begin
                if (bus.rx_done_tick) begin
                    if (bus.rx_data == init_rsp(state_q)) begin
                        enter = 1'b1;
                        case (state_q)
                            ST_ACK1: state_d = ST_BAT;
                            ST_BAT:  state_d = ST_ID;
                            ST_ID:   state_d = ST_TX_EN;
                            default: state_d = ST_S0;
                        endcase
                    end else begin
                        bad = 1'b1;
                    end
                end else if (tmo_exp) begin
                    bad = 1'b1;
                end
            end
            ST_S0: begin
                // Bytes without the sync bit cannot start a packet; drop them.
                if (bus.rx_done_tick && bus.rx_data[3]) begin
                    b0_d    = bus.rx_data;
                    state_d = ST_S1;
                    enter   = 1'b1;
                end
            end
            ST_S1: begin
                if (bus.rx_done_tick) begin
                    b1_d    = bus.rx_data;
                    state_d = ST_S2;
                    enter   = 1'b1;
                end else if (tmo_exp) begin
                    state_d = ST_S0;
                    enter   = 1'b1;
                end
            end
            ST_S2: begin
                if (bus.rx_done_tick) begin
                    upd     = pkt_w.hdr.sync;
                    state_d = ST_S0;
                    enter   = 1'b1;
                end else if (tmo_exp) begin
                    state_d = ST_S0;
                    enter   = 1'b1;
                end
            end
            default: ;
        endcase
        if (bad) begin
            enter   = 1'b1;
            retry_d = retry_q + RW'(1);
            state_d = (retry_q >= LAST_TRY) ? ST_FAIL : ST_TX_RST;
        end
        if (enter) sent_d = 1'b0;
    end

    assign tmo_d = enter ? '0 : (counting ? tmo_q + TW'(1) : tmo_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_TX_RST;
            tmo_q   <= '0;
            retry_q <= '0;
            sent_q  <= 1'b0;
            wr_q    <= 1'b0;
            txd_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            pv_q    <= 1'b0;
            btn_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            sent_q  <= sent_d;
            wr_q    <= wr_d;
            txd_q   <= txd_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            pv_q    <= upd;
            if (upd) begin
                btn_q <= pkt_w.hdr.btn;
                dx_q  <= {pkt_w.hdr.x_sign, pkt_w.x};
                dy_q  <= {pkt_w.hdr.y_sign, pkt_w.y};
            end
        end
    end

    ps2_mouse_cursor #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX)
    ) u_cursor (
        .clk    (clk),
        .rst    (rst),
        .upd_i  (upd),
        .dx_i   ({pkt_w.hdr.x_sign, pkt_w.x}),
        .dy_i   ({pkt_w.hdr.y_sign, pkt_w.y}),
        .x_ovf_i(pkt_w.hdr.x_ovf),
        .y_ovf_i(pkt_w.hdr.y_ovf),
        .x_o    (bus.cursor_x),
        .y_o    (bus.cursor_y)
    );

    assign bus.wr_ps2    = wr_q;
    assign bus.tx_data   = txd_q;
    assign bus.ready     = state_q inside {ST_S0, ST_S1, ST_S2};
    assign bus.init_fail = (state_q == ST_FAIL);
    assign bus.pkt_valid = pv_q;
    assign bus.pkt_btn   = btn_q;
    assign bus.pkt_dx    = dx_q;
    assign bus.pkt_dy    = dy_q;
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Randomized scoreboard bench for ps2_mouse_ctrl with a packet-level reference model.
module tb_ps2_mouse_ctrl;
    localparam int TMO  = 100;
    localparam int XMAX = 639;
    localparam int YMAX = 479;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot  = 0;

    ps2_mouse_ctrl_if m();

    ps2_mouse_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (3),
        .X_MAX         (XMAX),
        .Y_MAX         (YMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        int         cx;
        int         cy;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] part[$];
    int         mx = 320;
    int         my = 240;
    logic [7:0] wr_log[$];
    int         wr_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: parse stream bytes into packets and accumulate the cursor.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        int dx, dy;
        if (part.size() == 0 && !b[3]) return;
        part.push_back(b);
        if (part.size() == 3) begin
            dx = int'(part[1]) - (part[0][4] ? 256 : 0);
            dy = int'(part[2]) - (part[0][5] ? 256 : 0);
            if (!part[0][6]) mx = clampi(mx + dx, XMAX);
            if (!part[0][7]) my = clampi(my - dy, YMAX);
            e.btn = part[0][2:0];
            e.dx  = dx[8:0];
            e.dy  = dy[8:0];
            e.cx  = mx;
            e.cy  = my;
            sbq.push_back(e);
            part.delete();
        end
    endtask

    always @(negedge clk) begin
        if (m.wr_ps2) begin
            wr_log.push_back(m.tx_data);
            wr_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (m.pkt_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_pkt", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("pkt_btn", 32'(m.pkt_btn), 32'(e.btn));
                check("pkt_dx", 32'(m.pkt_dx), 32'(e.dx));
                check("pkt_dy", 32'(m.pkt_dy), 32'(e.dy));
                check("cursor_x", 32'(m.cursor_x), 32'(e.cx));
                check("cursor_y", 32'(m.cursor_y), 32'(e.cy));
            end
        end
    end

    // Transmitter model: busy for a few cycles after each request.
    initial begin
        m.tx_idle      = 1'b1;
        m.tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (m.wr_ps2) begin
                m.tx_idle = 1'b0;
                repeat (3) @(negedge clk);
                m.tx_done_tick = 1'b1;
                @(negedge clk);
                m.tx_done_tick = 1'b0;
                m.tx_idle      = 1'b1;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        m.rx_data      = b;
        m.rx_done_tick = 1'b1;
        @(negedge clk);
        m.rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic stream_byte(input logic [7:0] b);
        model_byte(b);
        send_rx(b);
    endtask

    task automatic stream_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        stream_byte(b0);
        stream_byte(b1);
        stream_byte(b2);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (wr_log.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("wr_arrived", 32'(wr_log.size() >= n), 32'd1);
        repeat (8) @(negedge clk);
    endtask

    task automatic init_seq(input bit wrong_bat);
        int base = wr_log.size();
        wait_wr(base + 1);
        send_rx(8'hFA);
        if (wrong_bat) begin
            send_rx(8'hFC);
            wait_wr(base + 2);
            send_rx(8'hFA);
        end
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_wr(wr_log.size() > base + 1 + int'(wrong_bat) ? 0 : base + 2 + int'(wrong_bat));
        send_rx(8'hFA);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        wr_log.delete();
        wr_cyc.delete();
        part.delete();
        mx = 320;
        my = 240;
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr"}, 32'(m.wr_ps2), 32'd0);
        check({tag, "_txd"}, 32'(m.tx_data), 32'd0);
        check({tag, "_ready"}, 32'(m.ready), 32'd0);
        check({tag, "_fail"}, 32'(m.init_fail), 32'd0);
        check({tag, "_pv"}, 32'(m.pkt_valid), 32'd0);
        check({tag, "_btn"}, 32'(m.pkt_btn), 32'd0);
        check({tag, "_dx"}, 32'(m.pkt_dx), 32'd0);
        check({tag, "_dy"}, 32'(m.pkt_dy), 32'd0);
        check({tag, "_cx"}, 32'(m.cursor_x), 32'd320);
        check({tag, "_cy"}, 32'(m.cursor_y), 32'd240);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, sp;
        logic [7:0] r0, r1, r2;
        m.rx_done_tick = 1'b0;
        m.rx_data      = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Silent device: three FF attempts spaced by the timeout, then FAIL.
        do_reset();
        k = 0;
        while (!m.init_fail && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("silent_fail", 32'(m.init_fail), 32'd1);
        check("silent_ff_cnt", 32'(wr_log.size()), 32'd3);
        if (wr_cyc.size() >= 2) begin
            sp = wr_cyc[1] - wr_cyc[0];
            check("silent_spacing", 32'(sp >= TMO && sp <= TMO + 10), 32'd1);
        end
        foreach (wr_log[i]) check("silent_ff_byte", 32'(wr_log[i]), 32'hFF);
        repeat (300) @(negedge clk);
        check("silent_no_more_wr", 32'(wr_log.size()), 32'd3);
        check("silent_ready", 32'(m.ready), 32'd0);
        check("silent_fail_sticky", 32'(m.init_fail), 32'd1);

        // Clean init.
        do_reset();
        init_seq(1'b0);
        check("clean_wr_cnt", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            check("clean_wr0", 32'(wr_log[0]), 32'hFF);
            check("clean_wr1", 32'(wr_log[1]), 32'hF4);
        end
        check("clean_ready", 32'(m.ready), 32'd1);
        check("clean_fail", 32'(m.init_fail), 32'd0);

        // Directed packets.
        stream_pkt(8'h09, 8'h10, 8'hF0);
        check("dir1_cx", 32'(m.cursor_x), 32'd336);
        check("dir1_cy", 32'(m.cursor_y), 32'd0);
        stream_pkt(8'h18, 8'hF0, 8'h10);
        check("dir2_cx", 32'(m.cursor_x), 32'd320);
        check("dir2_cy", 32'(m.cursor_y), 32'd0);

        // Resync: junk byte without sync bit, then a packet.
        stream_byte(8'h00);
        stream_pkt(8'h0A, 8'h05, 8'hFB);

        // Partial packet abandoned by timeout, then a full one.
        stream_byte(8'h08);
        stream_byte(8'h33);
        repeat (TMO + 50) @(negedge clk);
        part.delete();
        stream_pkt(8'h0C, 8'h21, 8'h07);

        // X overflow: delta ignored for cursor but still reported.
        stream_pkt(8'h58, 8'h7F, 8'h00);
        check("ovf_dx", 32'(m.pkt_dx), 32'h17F);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) stream_byte(8'($urandom_range(0, 255)) & 8'hF7);
            r0 = 8'($urandom_range(0, 255)) | 8'h08;
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            stream_pkt(r0, r1, r2);
        end
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        // Reset in the middle of a packet.
        send_rx(8'h08);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        wr_log.delete();
        wr_cyc.delete();
        part.delete();
        mx = 320;
        my = 240;
        rst = 1'b0;

        // Wrong BAT byte: one retry, then clean.
        init_seq(1'b1);
        check("retry_wr_cnt", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) begin
            check("retry_wr0", 32'(wr_log[0]), 32'hFF);
            check("retry_wr1", 32'(wr_log[1]), 32'hFF);
            check("retry_wr2", 32'(wr_log[2]), 32'hF4);
        end
        check("retry_ready", 32'(m.ready), 32'd1);
        stream_pkt(8'h29, 8'h04, 8'h80);
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
